// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: I/D-cache shared memory port arbiter with tagged read-return pipeline; ARB_RR_EN enables round-robin tie-break
module cache_mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_rd,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;
  state_t state, nxt;
  logic prefer_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MEM_LATENCY-1:0] vld, own;
`ifdef ARB_RR_EN
  logic last_d;
  assign prefer_d = ~last_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d <= 1'b0;
    else if (nxt != IDLE) last_d <= nxt == OWN_D;
  end
`else
  assign prefer_d = 1'b1;
`endif
  always_comb begin
    nxt = state == OWN_I ? (i_req ? OWN_I : d_req ? OWN_D : IDLE) :
          state == OWN_D ? (d_req ? OWN_D : i_req ? OWN_I : IDLE) :
          (d_req & (prefer_d | ~i_req)) ? OWN_D : i_req ? OWN_I : IDLE;
  end
  always_comb begin
    mem_en = state == OWN_I ? i_rd : state == OWN_D ? (d_rd | d_we) : 1'b0;
    mem_we = (state == OWN_D) & d_we;
    mem_addr = ~mem_en ? addr_q : state == OWN_D ? d_addr : i_addr;
    mem_wdata = state == OWN_D ? d_wdata : wdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i_grant <= 1'b0;
      d_grant <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      vld <= '0;
      own <= '0;
    end else begin
      state <= nxt;
      i_grant <= nxt == OWN_I;
      d_grant <= nxt == OWN_D;
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
      vld[0] <= mem_en & ~mem_we;
      own[0] <= state == OWN_D;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        vld[k] <= vld[k-1];
        own[k] <= own[k-1];
      end
    end
  end
  assign i_data_valid = vld[MEM_LATENCY-1] & ~own[MEM_LATENCY-1];
  assign d_data_valid = vld[MEM_LATENCY-1] & own[MEM_LATENCY-1];
  assign rdata = mem_rdata;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized and directed bench with a behavioural model of ownership and read returns
module tb_cache_mem_arbiter;
  localparam int L = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, i_req, i_rd, d_req, d_rd, d_we;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic i_grant, d_grant, i_data_valid, d_data_valid, mem_en, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;
  int n_chk = 0, n_pass = 0, cyc = 0, n_iv = 0, n_dv = 0;
  int ring [16];
  int m_own;
  logic m_last_d;
  logic [15:0] m_addr;
  logic e_en, e_we;
  logic [15:0] e_addr;
  int base_iv, base_dv;

  cache_mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_rd(i_rd), .i_addr(i_addr),
    .d_req(d_req), .d_rd(d_rd), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant), .i_data_valid(i_data_valid),
    .d_data_valid(d_data_valid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Model: owner as 0/1/2 (none/I/D), returns scheduled in a ring indexed by cycle
  always @(negedge clk) begin : cmp
    if (rst) begin
      m_own = 0;
      m_last_d = 1'b0;
      m_addr = '0;
      for (int k = 0; k < 16; k++) ring[k] = 0;
      chk("rst_i_grant", i_grant, 0);
      chk("rst_d_grant", d_grant, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_i_valid", i_data_valid, 0);
      chk("rst_d_valid", d_data_valid, 0);
    end else begin
      e_en = m_own == 1 ? i_rd : m_own == 2 ? (d_rd | d_we) : 1'b0;
      e_we = m_own == 2 && d_we;
      e_addr = !e_en ? m_addr : m_own == 2 ? d_addr : i_addr;
      chk("i_grant", i_grant, m_own == 1);
      chk("d_grant", d_grant, m_own == 2);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, d_wdata);
      chk("i_data_valid", i_data_valid, ring[cyc % 16] == 1);
      chk("d_data_valid", d_data_valid, ring[cyc % 16] == 2);
      if (ring[cyc % 16] != 0) chk("rdata", rdata, mem_rdata);
      ring[cyc % 16] = 0;
      if (e_en && !e_we) ring[(cyc + L) % 16] = m_own;
      m_addr = e_addr;
      if (m_own == 1 && !i_req) m_own = d_req ? 2 : 0;
      else if (m_own == 2 && !d_req) m_own = i_req ? 1 : 0;
      else if (m_own == 0) begin
        if (i_req && d_req) m_own = (RR && m_last_d) ? 1 : 2;
        else if (d_req) m_own = 2;
        else if (i_req) m_own = 1;
      end
      if (m_own == 1) m_last_d = 1'b0;
      if (m_own == 2) m_last_d = 1'b1;
    end
    if (i_data_valid) n_iv++;
    if (d_data_valid) n_dv++;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    mem_rdata = 16'($urandom);
  endtask

  task automatic quiet();
    i_req = 0; i_rd = 0; i_addr = 0;
    d_req = 0; d_rd = 0; d_we = 0; d_addr = 0; d_wdata = 0;
  endtask

  initial begin
    rst = 1'b1;
    mem_rdata = 0;
    quiet();
    repeat (3) step();
    rst = 1'b0;
    step();
    // I-only fill of 8 words
    i_req = 1;
    step();
    i_rd = 1; i_addr = 16'h1230;
    base_iv = n_iv; base_dv = n_dv;
    @(negedge clk);
    chk("fill_i_grant", i_grant, 1);
    chk("fill_mem_addr0", mem_addr, 16'h1230);
    for (int k = 1; k < 8; k++) begin
      step();
      i_addr = 16'(16'h1230 + 2 * k);
    end
    step();
    i_rd = 0; i_req = 0;
    repeat (6) step();
    chk("fill_i_pulses", n_iv - base_iv, 8);
    chk("fill_d_pulses", n_dv - base_dv, 0);
    // simultaneous request then hand-over D -> I with D words in flight
    i_req = 1; d_req = 1;
    step();
    d_rd = 1; d_addr = 16'h4000;
    @(negedge clk);
    chk("simul_d_grant", d_grant, 1);
    chk("simul_i_grant", i_grant, 0);
    step();
    d_addr = 16'h4002;
    step();
    d_req = 0; d_rd = 0;
    step();
    i_rd = 1; i_addr = 16'h2000;
    @(negedge clk);
    chk("handover_i_grant", i_grant, 1);
    step();
    i_addr = 16'h2002;
    @(negedge clk);
    chk("handover_d_word0", d_data_valid, 1);
    step();
    i_rd = 0;
    @(negedge clk);
    chk("handover_d_word1", d_data_valid, 1);
    step();
    @(negedge clk);
    chk("handover_gap", d_data_valid | i_data_valid, 0);
    step();
    @(negedge clk);
    chk("handover_i_word0", i_data_valid, 1);
    step();
    i_req = 0;
    @(negedge clk);
    chk("handover_i_word1", i_data_valid, 1);
    repeat (2) step();
    // prior D ownership, then simultaneous request
    d_req = 1;
    step();
    step();
    d_req = 0;
    step();
    step();
    i_req = 1; d_req = 1;
    step();
    @(negedge clk);
    chk("tie_i_grant", i_grant, RR);
    chk("tie_d_grant", d_grant, !RR);
    step();
    i_req = 0;
    repeat (2) step();
    // write-through in OWN_D
    d_we = 1; d_addr = 16'h00F0; d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 16'h00F0);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    step();
    d_we = 0;
    repeat (3) step();
    @(negedge clk);
    chk("wr_no_return", d_data_valid | i_data_valid, 0);
    step();
    quiet();
    repeat (2) step();
    // non-owner strobes while I owns the port
    i_req = 1;
    repeat (2) step();
    for (int k = 0; k < 6; k++) begin
      d_rd = 1; d_we = 1; d_addr = 16'h5555; d_wdata = 16'h1111;
      i_rd = 1'($urandom); i_addr = 16'(16'h1000 + k);
      @(negedge clk);
      chk("nonowner_we", mem_we, 0);
      chk("nonowner_addr", mem_addr != 16'h5555, 1);
      step();
    end
    d_rd = 0; d_we = 0;
    // reset with 3 reads in flight
    for (int k = 0; k < 3; k++) begin
      i_rd = 1; i_addr = 16'(16'h3000 + 2 * k);
      step();
    end
    i_rd = 0; rst = 1;
    step();
    rst = 0; i_req = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("postrst_valid", i_data_valid | d_data_valid, 0);
      chk("postrst_grant", i_grant | d_grant, 0);
      step();
    end
    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) i_req = ~i_req;
      if ($urandom_range(7) == 0) d_req = ~d_req;
      i_rd = 1'($urandom);
      d_rd = 1'($urandom);
      d_we = $urandom_range(3) == 0;
      i_addr = 16'($urandom);
      d_addr = 16'($urandom);
      d_wdata = 16'($urandom);
      rst = $urandom_range(299) == 0;
      step();
    end
    rst = 0;
    quiet();
    repeat (L + 2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
